// File: rtl/serial_mod_n_if.sv
// serial_mod_n_if: bundles the frame/data inputs and the result outputs of the
// bit-serial modulo engine.
//
// Handshake: in_valid has no ready. Every cycle with in_valid=1 (and start=1,
// or the engine in RUN) consumes in/last in that cycle. q_valid and done are
// single-cycle pulses with no ready.
//
// Signals:
//   start, divisor_in, in_valid, in, last  driven by the master (stimulus side)
//   rem, div, q_bit, q_valid, done, err,
//   bit_cnt, dbg_state                     driven by the slave (engine)
//   dbg_state exposes the FSM state: 0=IDLE, 1=RUN, 2=DONE.
interface serial_mod_n_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [W-1:0]     divisor_in;
  logic             in_valid;
  logic             in;
  logic             last;
  logic [W-1:0]     rem;
  logic             div;
  logic             q_bit;
  logic             q_valid;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output start, divisor_in, in_valid, in, last,
    input  rem, div, q_bit, q_valid, done, err, bit_cnt, dbg_state
  );

  modport slave (
    input  start, divisor_in, in_valid, in, last,
    output rem, div, q_bit, q_valid, done, err, bit_cnt, dbg_state
  );
endinterface

// File: rtl/serial_mod_n.sv
// serial_mod_n: bit-serial, MSB-first modulo/divider engine with a runtime
// divisor. Each accepted bit performs one long-division step, producing a
// quotient bit and the running remainder of the word received so far.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    serial_mod_n_if.slave (start/divisor_in/in_valid/in/last in;
//          rem/div/q_bit/q_valid/done/err/bit_cnt/dbg_state out)
module serial_mod_n #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_mod_n_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             q_bit_q, q_bit_d;
  logic             q_valid_q, q_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operands of the division step; a start in the same cycle replaces them
  // so the coincident bit is the first bit of the new frame.
  logic             accept;
  logic [W-1:0]     base_d;
  logic [W-1:0]     base_rem;
  logic [CNT_W-1:0] base_cnt;
  logic [W:0]       t;
  logic [W:0]       t_sub;

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    rem_d     = rem_q;
    q_bit_d   = q_bit_q;
    q_valid_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    base_d    = d_q;
    base_rem  = rem_q;
    base_cnt  = cnt_q;
    t         = '0;
    t_sub     = '0;

    if (bus.start) begin
      // Opening (or aborting into) a frame: same action from every state.
      state_d  = RUN;
      d_d      = bus.divisor_in;
      rem_d    = '0;
      cnt_d    = '0;
      err_d    = (bus.divisor_in == '0);
      base_d   = bus.divisor_in;
      base_rem = '0;
      base_cnt = '0;
      accept   = bus.in_valid;
    end else if (state_q == RUN) begin
      accept = bus.in_valid;
    end

    if (accept) begin
      // rem < D, so t < 2D and one conditional subtract restores rem < D.
      t     = {base_rem, 1'b0} + {{W{1'b0}}, bus.in};
      t_sub = t - {1'b0, base_d};
      if (base_d == '0) begin
        // Zero divisor: count bits but keep the remainder pinned at 0.
        rem_d   = '0;
        q_bit_d = 1'b0;
      end else if (t >= {1'b0, base_d}) begin
        rem_d   = t_sub[W-1:0];
        q_bit_d = 1'b1;
      end else begin
        rem_d   = t[W-1:0];
        q_bit_d = 1'b0;
      end
      q_valid_d = 1'b1;
      cnt_d     = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 1'b1;
      if (bus.last) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      d_q       <= '0;
      rem_q     <= '0;
      q_bit_q   <= 1'b0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      rem_q     <= rem_d;
      q_bit_q   <= q_bit_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.rem       = rem_q;
  assign bus.div       = (state_q != IDLE) && (rem_q == '0);
  assign bus.q_bit     = q_bit_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.bit_cnt   = cnt_q;
  assign bus.dbg_state = state_q;

endmodule
